// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared sizing helpers for the 1D CNN datapath
package cnn1d_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Windows that fit entirely inside one sequence; also used for layer sizing.
    function automatic int num_windows(input int seq_len, input int kernel_size, input int stride);
        return (seq_len - kernel_size) / stride + 1;
    endfunction

endpackage

// File: rtl/window_gen.sv
// rtl/window_gen.sv - sliding-window generator feeding the neuron stage
module window_gen
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int SEQ_LEN     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  window_ready_in,
    input  logic                  window_valid_in,
    input  logic [DATA_WIDTH-1:0] window_data_in,
    input  logic                  window_ready_out,
    output logic                  window_valid_out,
    output logic [DATA_WIDTH-1:0] window_data_out [0:KERNEL_SIZE-1],
    output logic                  window_last_out
);

    localparam int IDX_W   = (clog2(SEQ_LEN) < 1) ? 1 : clog2(SEQ_LEN);
    localparam int PH_W    = (clog2(STRIDE) < 1) ? 1 : clog2(STRIDE);
    localparam int NUM_WIN = num_windows(SEQ_LEN, KERNEL_SIZE, STRIDE);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KERNEL_SIZE - 1 + (NUM_WIN - 1) * STRIDE);
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(SEQ_LEN - 1);
    localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(STRIDE - 1);

    logic [DATA_WIDTH-1:0] r_shift [0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] r_data  [0:KERNEL_SIZE-1];
    logic [IDX_W-1:0]      r_idx;
    logic [PH_W-1:0]       r_phase;
    logic                  r_valid;
    logic                  r_last;

    logic [DATA_WIDTH-1:0] w_shift_next [0:KERNEL_SIZE-1];
    logic                  w_accept;
    logic                  w_emit;

    assign window_ready_in  = ~r_valid | window_ready_out;
    assign window_valid_out = r_valid;
    assign window_last_out  = r_last;
    assign window_data_out  = r_data;

    assign w_accept = window_valid_in & window_ready_in;
    // Phase only advances once a full kernel is present, so phase==0 marks stride alignment.
    assign w_emit   = w_accept && (r_idx >= FIRST_IDX) && (r_phase == '0);

    always_comb begin
        for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            w_shift_next[j] = r_shift[j+1];
        end
        w_shift_next[KERNEL_SIZE-1] = window_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                r_shift[j] <= '0;
                r_data[j]  <= '0;
            end
            r_idx   <= '0;
            r_phase <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift <= w_shift_next;
                if (r_idx == END_IDX) begin
                    r_idx   <= '0;
                    r_phase <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx >= FIRST_IDX) begin
                        r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + PH_W'(1);
                    end
                end
            end

            // A new window replaces the old one in the same edge it is consumed.
            if (w_emit) begin
                r_data  <= w_shift_next;
                r_valid <= 1'b1;
                r_last  <= (r_idx == LAST_IDX);
            end else if (window_ready_out) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - directed self-checking bench for window_gen
module tb_window_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vin  = 4'b0000;
    logic [3:0]  rout = 4'b1111;
    logic [11:0] din [4];
    wire  [3:0]  rin;
    wire  [3:0]  vo;
    wire  [3:0]  lo;
    wire  [11:0] w0 [0:2];
    wire  [11:0] w1 [0:2];
    wire  [11:0] w2 [0:2];
    wire  [11:0] w3 [0:3];

    int n_chk = 0;
    int n_err = 0;
    logic [50:0] obs [$];
    logic [50:0] exq [$];

    always #5 clk = ~clk;

    window_gen #(.DATA_WIDTH(12), .KERNEL_SIZE(3), .STRIDE(1), .SEQ_LEN(8)) u_a (
        .clk(clk), .rst(rst), .window_ready_in(rin[0]), .window_valid_in(vin[0]),
        .window_data_in(din[0]), .window_ready_out(rout[0]), .window_valid_out(vo[0]),
        .window_data_out(w0), .window_last_out(lo[0]));
    window_gen #(.DATA_WIDTH(12), .KERNEL_SIZE(3), .STRIDE(2), .SEQ_LEN(8)) u_b (
        .clk(clk), .rst(rst), .window_ready_in(rin[1]), .window_valid_in(vin[1]),
        .window_data_in(din[1]), .window_ready_out(rout[1]), .window_valid_out(vo[1]),
        .window_data_out(w1), .window_last_out(lo[1]));
    window_gen #(.DATA_WIDTH(12), .KERNEL_SIZE(3), .STRIDE(1), .SEQ_LEN(4)) u_c (
        .clk(clk), .rst(rst), .window_ready_in(rin[2]), .window_valid_in(vin[2]),
        .window_data_in(din[2]), .window_ready_out(rout[2]), .window_valid_out(vo[2]),
        .window_data_out(w2), .window_last_out(lo[2]));
    window_gen #(.DATA_WIDTH(12), .KERNEL_SIZE(4), .STRIDE(3), .SEQ_LEN(13)) u_d (
        .clk(clk), .rst(rst), .window_ready_in(rin[3]), .window_valid_in(vin[3]),
        .window_data_in(din[3]), .window_ready_out(rout[3]), .window_valid_out(vo[3]),
        .window_data_out(w3), .window_last_out(lo[3]));

    // Completed output handshakes, tagged with the instance number.
    always @(negedge clk) begin
        if (vo[0] && rout[0]) obs.push_back({2'd0, lo[0], w0[0], w0[1], w0[2], 12'h0});
        if (vo[1] && rout[1]) obs.push_back({2'd1, lo[1], w1[0], w1[1], w1[2], 12'h0});
        if (vo[2] && rout[2]) obs.push_back({2'd2, lo[2], w2[0], w2[1], w2[2], 12'h0});
        if (vo[3] && rout[3]) obs.push_back({2'd3, lo[3], w3[0], w3[1], w3[2], w3[3]});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [50:0] mk(input int inst, input bit l, input int a, input int b,
                                       input int c, input int d);
        return {2'(inst), l, 12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 64'(obs.size()), 64'(exq.size()));
        for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
            check($sformatf("%s_win%0d", tag, i), 64'(obs[i]), 64'(exq[i]));
        end
        obs.delete();
        exq.delete();
    endtask

    // Instance 0, one sample per cycle, checked directly one cycle after each accept.
    task automatic stream_a(input int upto);
        for (int n = 1; n <= upto; n++) begin
            vin[0] = 1'b1;
            din[0] = 12'(n);
            @(posedge clk); #1;
            check($sformatf("a_valid%0d", n), 64'(vo[0]), 64'(n >= 3));
            if (n >= 3) begin
                check($sformatf("a_data%0d", n), 64'({w0[0], w0[1], w0[2]}),
                      64'({12'(n-2), 12'(n-1), 12'(n)}));
                check($sformatf("a_last%0d", n), 64'(lo[0]), 64'(n == 8));
            end
        end
        vin[0] = 1'b0;
    endtask

    task automatic run(input int k, input int first, input int last_s, input bit rnd);
        int  s;
        int  cyc;
        bit  acc;
        s   = first;
        cyc = 0;
        while (s <= last_s && cyc < 2000) begin
            vin[k]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            din[k]  = 12'(s);
            rout[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = vin[k] && rin[k];
            @(posedge clk); #1;
            if (acc) s++;
            cyc++;
        end
        check($sformatf("run%0d_done", k), 64'(s), 64'(last_s + 1));
        vin[k]  = 1'b0;
        rout[k] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(vo), 64'(0));
        check("rst_last", 64'(lo), 64'(0));
        check("rst_data_a", 64'({w0[0], w0[1], w0[2]}), 64'(0));
        check("rst_ready_in", 64'(rin), 64'(4'hf));
        rst = 1'b0;

        stream_a(8);
        @(posedge clk); #1;
        check("a_valid_clear", 64'(vo[0]), 64'(0));

        // Reset in the middle of a sequence, then restart from scratch.
        stream_a(5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 64'(vo[0]), 64'(0));
        check("mid_rst_last", 64'(lo[0]), 64'(0));
        check("mid_rst_data", 64'({w0[0], w0[1], w0[2]}), 64'(0));
        stream_a(8);
        @(posedge clk); #1;
        obs.delete();

        // Backpressure: stall the first window for 5 cycles.
        for (int n = 1; n <= 3; n++) begin
            vin[0] = 1'b1;
            din[0] = 12'(n);
            @(posedge clk); #1;
        end
        rout[0] = 1'b0;
        din[0]  = 12'd4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_ready_in%0d", c), 64'(rin[0]), 64'(0));
            check($sformatf("bp_valid%0d", c), 64'(vo[0]), 64'(1));
            check($sformatf("bp_data%0d", c), 64'({w0[0], w0[1], w0[2]}),
                  64'({12'd1, 12'd2, 12'd3}));
            @(posedge clk); #1;
        end
        run(0, 4, 8, 1'b0);
        for (int n = 3; n <= 8; n++) exq.push_back(mk(0, n == 8, n-2, n-1, n, 0));
        compare_q("bp");

        run(1, 1, 8, 1'b0);
        exq.push_back(mk(1, 0, 1, 2, 3, 0));
        exq.push_back(mk(1, 0, 3, 4, 5, 0));
        exq.push_back(mk(1, 1, 5, 6, 7, 0));
        compare_q("stride2");

        run(2, 1, 8, 1'b0);
        exq.push_back(mk(2, 0, 1, 2, 3, 0));
        exq.push_back(mk(2, 1, 2, 3, 4, 0));
        exq.push_back(mk(2, 0, 5, 6, 7, 0));
        exq.push_back(mk(2, 1, 6, 7, 8, 0));
        compare_q("seq4");

        run(3, 1, 13, 1'b1);
        exq.push_back(mk(3, 0, 1, 2, 3, 4));
        exq.push_back(mk(3, 0, 4, 5, 6, 7));
        exq.push_back(mk(3, 0, 7, 8, 9, 10));
        exq.push_back(mk(3, 1, 10, 11, 12, 13));
        compare_q("rand_k4s3");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
